// File: rtl/signal_shifter_sequencer_if.sv
// Bus bundle between the AXI command decoder (master) and the shifter sequencer (slave).
// With SHIFTER_SEQ_READBACK_EN defined, the bundle also carries the table readback port.
interface signal_shifter_sequencer_if #(
  parameter int unsigned DELAY_WIDTH = 30,
  parameter int unsigned EVENT_WIDTH = 10,
  parameter int unsigned AW          = 4
);
  logic                   cfg_wr_en;
  logic [AW-1:0]          cfg_wr_addr;
  logic [EVENT_WIDTH:0]   cfg_wr_data;
  logic                   cfg_wr_err;
  logic                   cmd_start;
  logic                   cmd_ready;
  logic [DELAY_WIDTH-1:0] cmd_delay;
  logic [AW:0]            cmd_count;
  logic                   cmd_err;
  logic                   abort;
  logic                   busy;
  logic                   done;
  logic                   aborted;
  logic                   reset;
  logic [DELAY_WIDTH-1:0] delay_value;
  logic                   delay_set;
  logic [EVENT_WIDTH-1:0] event_value;
  logic                   event_set;
  logic                   event_polarity_set;
`ifdef SHIFTER_SEQ_READBACK_EN
  logic [AW-1:0]          rd_addr;
  logic [EVENT_WIDTH:0]   rd_data;

  modport master (
    output cfg_wr_en, cfg_wr_addr, cfg_wr_data, cmd_start, cmd_delay, cmd_count, abort, rd_addr,
    input  cfg_wr_err, cmd_ready, cmd_err, busy, done, aborted, reset,
           delay_value, delay_set, event_value, event_set, event_polarity_set, rd_data
  );
  modport slave (
    input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, cmd_start, cmd_delay, cmd_count, abort, rd_addr,
    output cfg_wr_err, cmd_ready, cmd_err, busy, done, aborted, reset,
           delay_value, delay_set, event_value, event_set, event_polarity_set, rd_data
  );
`else
  modport master (
    output cfg_wr_en, cfg_wr_addr, cfg_wr_data, cmd_start, cmd_delay, cmd_count, abort,
    input  cfg_wr_err, cmd_ready, cmd_err, busy, done, aborted, reset,
           delay_value, delay_set, event_value, event_set, event_polarity_set
  );
  modport slave (
    input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, cmd_start, cmd_delay, cmd_count, abort,
    output cfg_wr_err, cmd_ready, cmd_err, busy, done, aborted, reset,
           delay_value, delay_set, event_value, event_set, event_polarity_set
  );
`endif
endinterface

// File: rtl/signal_shifter_sequencer.sv
// Signal shifter sequencer: replays a local event table onto the shifter config port
// as reset pulse, delay load, then one event load per entry, GAP idle cycles apart.
// Optional macro SHIFTER_SEQ_READBACK_EN adds a 1-cycle-latency table readback port.
module signal_shifter_sequencer #(
  parameter int unsigned MAX_DELAY   = 1000000000,
  parameter int unsigned MAX_EVENT   = 1000,
  parameter int unsigned DELAY_WIDTH = $clog2(MAX_DELAY),
  parameter int unsigned EVENT_WIDTH = $clog2(MAX_EVENT),
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned GAP         = 2,
  parameter int unsigned AW          = $clog2(DEPTH)
) (
  input logic                    s_axi_aclk,
  input logic                    s_axi_aresetn,
  signal_shifter_sequencer_if.slave bus
);

  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = EVENT_WIDTH + 1;
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_DLY, S_EVT, S_GAPW, S_DONE, S_ABRT
  } state_t;

  state_t                 state;
  logic [DELAY_WIDTH-1:0] dly_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          idx_q;
  logic [GW-1:0]          gap_q;
  logic                   dly_pend;
  logic [TW-1:0]          tbl [DEPTH];
  logic [TW-1:0]          rd_q;

  logic                   wr_err_q;
  logic                   ready_q;
  logic                   cmd_err_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   aborted_q;
  logic                   reset_q;
  logic [DELAY_WIDTH-1:0] delay_value_q;
  logic                   delay_set_q;
  logic [EVENT_WIDTH-1:0] event_value_q;
  logic                   event_set_q;
  logic                   pol_set_q;

  // Event table: writes only while idle; entry[idx] is read every cycle so the
  // next entry is already registered by the time the gap expires.
  always_ff @(posedge s_axi_aclk) begin
    if (bus.cfg_wr_en && state == S_IDLE) tbl[bus.cfg_wr_addr] <= bus.cfg_wr_data;
    rd_q <= tbl[idx_q[AW-1:0]];
  end

  // Sequencer FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state         <= S_IDLE;
      dly_q         <= '0;
      cnt_q         <= '0;
      idx_q         <= '0;
      gap_q         <= '0;
      dly_pend      <= 1'b0;
      wr_err_q      <= 1'b0;
      ready_q       <= 1'b1;
      cmd_err_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      reset_q       <= 1'b0;
      delay_value_q <= '0;
      delay_set_q   <= 1'b0;
      event_value_q <= '0;
      event_set_q   <= 1'b0;
      pol_set_q     <= 1'b0;
    end else begin
      wr_err_q    <= bus.cfg_wr_en && (state != S_IDLE);
      cmd_err_q   <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      reset_q     <= 1'b0;
      delay_set_q <= 1'b0;
      event_set_q <= 1'b0;
      pol_set_q   <= 1'b0;
      if (state != S_IDLE && state != S_ABRT && bus.abort) begin
        state     <= S_ABRT;
        reset_q   <= 1'b1;
        aborted_q <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.cmd_start) begin
              if (bus.cmd_count <= CW'(DEPTH)) begin
                dly_q    <= bus.cmd_delay;
                cnt_q    <= bus.cmd_count;
                idx_q    <= '0;
                dly_pend <= 1'b1;
                state    <= S_RST;
                reset_q  <= 1'b1;
                busy_q   <= 1'b1;
                ready_q  <= 1'b0;
              end else begin
                cmd_err_q <= 1'b1;
              end
            end
          end
          S_RST, S_DLY, S_EVT: begin
            state <= S_GAPW;
            gap_q <= '0;
          end
          S_GAPW: begin
            if (gap_q == GW'(GAP - 1)) begin
              if (dly_pend) begin
                state         <= S_DLY;
                dly_pend      <= 1'b0;
                delay_set_q   <= 1'b1;
                delay_value_q <= dly_q;
              end else if (idx_q < cnt_q) begin
                state         <= S_EVT;
                event_set_q   <= 1'b1;
                event_value_q <= rd_q[EVENT_WIDTH-1:0];
                pol_set_q     <= rd_q[EVENT_WIDTH];
                idx_q         <= idx_q + CW'(1);
              end else begin
                state  <= S_DONE;
                done_q <= 1'b1;
              end
            end else begin
              gap_q <= gap_q + GW'(1);
            end
          end
          S_DONE, S_ABRT: begin
            state   <= S_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef SHIFTER_SEQ_READBACK_EN
  logic [TW-1:0] rd_data_q;

  // Readback port, independent of the sequencer state.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) rd_data_q <= '0;
    else                rd_data_q <= tbl[bus.rd_addr];
  end

  assign bus.rd_data = rd_data_q;
`endif

  assign bus.cfg_wr_err         = wr_err_q;
  assign bus.cmd_ready          = ready_q;
  assign bus.cmd_err            = cmd_err_q;
  assign bus.busy               = busy_q;
  assign bus.done               = done_q;
  assign bus.aborted            = aborted_q;
  assign bus.reset              = reset_q;
  assign bus.delay_value        = delay_value_q;
  assign bus.delay_set          = delay_set_q;
  assign bus.event_value        = event_value_q;
  assign bus.event_set          = event_set_q;
  assign bus.event_polarity_set = pol_set_q;

endmodule

// File: tb/tb_signal_shifter_sequencer.sv
// Scoreboard bench for signal_shifter_sequencer: every start pushes its expected strobe
// schedule (cycle, kind, value); a negedge monitor pops and compares each observed strobe.
module tb_signal_shifter_sequencer;

  localparam int DW    = 30;
  localparam int EW    = 10;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int G     = 2;

  localparam int K_RST  = 0;
  localparam int K_DLY  = 1;
  localparam int K_EVT  = 2;
  localparam int K_DONE = 3;
  localparam int K_ABRT = 4;
  localparam int K_CERR = 5;
  localparam int K_WERR = 6;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t q[$];
  logic [EW:0] mdl [DEPTH];

  signal_shifter_sequencer_if #(.DELAY_WIDTH(DW), .EVENT_WIDTH(EW), .AW(AW)) bus ();

  signal_shifter_sequencer #(.DEPTH(DEPTH), .GAP(G)) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rst_n),
    .bus          (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL timeout: run did not complete, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  task automatic push_exp(input int c, input int k, input logic [31:0] v);
    exp_t e;
    int   i;
    e = '{cyc: c, kind: k, val: v};
    i = 0;
    while (i < q.size() && (q[i].cyc * 8 + q[i].kind) <= (c * 8 + k)) i++;
    q.insert(i, e);
  endtask

  task automatic sb_check(input int k, input logic [31:0] v);
    exp_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_strobe kind=%0d val=%0h @cyc %0d: nothing expected", k, v, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.val !== v) begin
        n_fail++;
        $display("FAIL strobe got kind=%0d cyc=%0d val=%0h expected kind=%0d cyc=%0d val=%0h",
                 k, cyc, v, e.kind, e.cyc, e.val);
      end
    end
  endtask

  // Monitor: strobes within one cycle are examined in ascending kind order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.reset && !bus.aborted) sb_check(K_RST, 32'd1);
      if (bus.delay_set) sb_check(K_DLY, 32'(bus.delay_value));
      if (bus.event_set || bus.event_polarity_set)
        sb_check(K_EVT, 32'({bus.event_set, bus.event_polarity_set, bus.event_value}));
      if (bus.done) sb_check(K_DONE, 32'd1);
      if (bus.aborted) sb_check(K_ABRT, 32'(bus.reset));
      if (bus.cmd_err) sb_check(K_CERR, 32'd1);
      if (bus.cfg_wr_err) sb_check(K_WERR, 32'd1);
    end
  end

  // Idle-time table write (called just after a negedge, returns just after one).
  task automatic write_idle(input int a, input logic [EW:0] d);
    bus.cfg_wr_en   = 1'b1;
    bus.cfg_wr_addr = AW'(a);
    bus.cfg_wr_data = d;
    mdl[a]          = d;
    @(negedge clk);
    bus.cfg_wr_en = 1'b0;
  endtask

  // One start command; ab_off/wr_off (<0 = none) are cycles after the start cycle.
  task automatic run(input int n, input logic [DW-1:0] d, input int ab_off,
                     input int wr_off, input int wa, input logic [EW:0] wd);
    int t0, done_c, lim, end_c;
    bit do_wr;
    t0 = cyc;
    bus.cmd_start = 1'b1;
    bus.cmd_delay = d;
    bus.cmd_count = 5'(n);
    if (n > DEPTH) begin
      push_exp(t0 + 1, K_CERR, 32'd1);
      end_c = t0 + 1;
    end else begin
      done_c = t0 + 3 + 2 * G + n * (1 + G);
      lim    = (ab_off >= 0) ? t0 + ab_off : done_c;
      push_exp(t0 + 1, K_RST, 32'd1);
      if (t0 + 2 + G <= lim) push_exp(t0 + 2 + G, K_DLY, 32'(d));
      for (int k = 0; k < n; k++)
        if (t0 + 3 + 2 * G + k * (1 + G) <= lim)
          push_exp(t0 + 3 + 2 * G + k * (1 + G), K_EVT, 32'({1'b1, mdl[k]}));
      if (done_c <= lim) push_exp(done_c, K_DONE, 32'd1);
      if (ab_off >= 0) begin
        push_exp(t0 + ab_off + 1, K_ABRT, 32'd1);
        end_c = t0 + ab_off + 1;
      end else begin
        end_c = done_c;
      end
    end
    do_wr = (wr_off >= 1) && (t0 + wr_off <= end_c - 2);
    if (do_wr) push_exp(t0 + wr_off + 1, K_WERR, 32'd1);
    @(negedge clk);
    bus.cmd_start = 1'b0;
    while (cyc < end_c + 1) begin
      bus.abort = (ab_off >= 0) && (cyc == t0 + ab_off);
      if (do_wr && cyc == t0 + wr_off) begin
        bus.cfg_wr_en   = 1'b1;
        bus.cfg_wr_addr = AW'(wa);
        bus.cfg_wr_data = wd;
      end else begin
        bus.cfg_wr_en = 1'b0;
      end
      @(negedge clk);
    end
    bus.abort     = 1'b0;
    bus.cfg_wr_en = 1'b0;
    chk("ready_after_run", 32'(bus.cmd_ready), 32'd1);
    chk("busy_after_run", 32'(bus.busy), 32'd0);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int t0, n, ab, wr, lim;
    bus.cfg_wr_en   = 1'b0;
    bus.cfg_wr_addr = '0;
    bus.cfg_wr_data = '0;
    bus.cmd_start   = 1'b0;
    bus.cmd_delay   = '0;
    bus.cmd_count   = '0;
    bus.abort       = 1'b0;
`ifdef SHIFTER_SEQ_READBACK_EN
    bus.rd_addr     = '0;
`endif
    #12;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_strobes", 32'({bus.reset, bus.delay_set, bus.event_set, bus.event_polarity_set,
                            bus.done, bus.aborted, bus.cmd_err, bus.cfg_wr_err}), 32'd0);
    chk("rst_buses", 32'(bus.delay_value) | 32'(bus.event_value), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < DEPTH; i++) write_idle(i, (EW + 1)'($urandom));
    write_idle(0, {1'b0, 10'd5});
    write_idle(1, {1'b1, 10'd7});
    write_idle(2, {1'b0, 10'd9});

    run(3, 30'd100, -1, -1, 0, '0);                  // normal run
    run(0, 30'd55, -1, -1, 0, '0);                   // zero count
    run(DEPTH + 1, 30'd1, -1, -1, 0, '0);            // over-range count
    run(3, 30'd100, 8, -1, 0, '0);                   // abort mid-run
    run(3, 30'd100, -1, 5, 1, {1'b0, 10'd999});      // write while busy is dropped
    run(3, 30'd100, -1, -1, 0, '0);                  // original values still emitted

    // Async reset in the middle of a run.
    t0 = cyc;
    bus.cmd_start = 1'b1;
    bus.cmd_delay = 30'd100;
    bus.cmd_count = 5'd3;
    push_exp(t0 + 1, K_RST, 32'd1);
    push_exp(t0 + 2 + G, K_DLY, 32'd100);
    push_exp(t0 + 3 + 2 * G, K_EVT, 32'({1'b1, mdl[0]}));
    @(negedge clk);
    bus.cmd_start = 1'b0;
    while (cyc < t0 + 3 + 2 * G) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_strobes", 32'({bus.reset, bus.delay_set, bus.event_set, bus.event_polarity_set,
                             bus.done, bus.aborted}), 32'd0);
    chk("arst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_drained", 32'(q.size()), 32'd0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_ready_after", 32'(bus.cmd_ready), 32'd1);
`ifdef SHIFTER_SEQ_READBACK_EN
    bus.rd_addr = 4'd1;
    @(negedge clk);
    chk("readback_entry1", 32'(bus.rd_data), 32'({1'b1, 10'd7}));
`endif
    run(3, 30'd100, -1, -1, 0, '0);

    // Randomized runs against the schedule model.
    for (int it = 0; it < 30; it++) begin
      for (int w = $urandom_range(0, 2); w > 0; w--)
        write_idle($urandom_range(0, DEPTH - 1), (EW + 1)'($urandom));
      if ($urandom_range(0, 8) == 0) n = DEPTH + 1 + $urandom_range(0, 14);
      else n = $urandom_range(0, DEPTH);
      lim = 3 + 2 * G + ((n > DEPTH) ? 0 : n) * (1 + G);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lim) : -1;
      wr  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : -1;
      run(n, DW'($urandom), ab, wr, $urandom_range(0, DEPTH - 1), (EW + 1)'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/signal_shifter_sequencer.md
# signal_shifter_sequencer

Command-driven sequencer that programs the signal shifter's configuration port from a local event table. The AXI command decoder loads up to `DEPTH` event entries, each holding an event count and a polarity bit, then issues one start command carrying the delay and the entry count. The sequencer then emits, in order:

- a shifter reset pulse;
- a delay load;
- one event load per entry, with a programmable idle gap between every strobe.

It sits between the AXI command decoder and the signal shifter, and replaces direct register pokes.

## Interface
Parameters:
- `MAX_DELAY`, 1000000000: maximum delay value.
- `MAX_EVENT`, 1000: maximum event value.
- `DELAY_WIDTH`, `$clog2(MAX_DELAY)`: delay bus width.
- `EVENT_WIDTH`, `$clog2(MAX_EVENT)`: event bus width.
- `DEPTH`, 16: event table entries; must be a power of two and ≥2.
- `GAP`, 2: idle cycles after each strobe; must be ≥1.
- `AW`, `$clog2(DEPTH)`: table address width.

Ports:
- `s_axi_aclk` in 1: sole clock.
- `s_axi_aresetn` in 1: asynchronous, active-low reset.
- `cfg_wr_en` in 1: table write strobe.
- `cfg_wr_addr` in AW: table write address.
- `cfg_wr_data` in EVENT_WIDTH+1: `{polarity, event}`.
- `cfg_wr_err` out 1: one-cycle pulse when a write is dropped.
- `cmd_start` in 1: start request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_delay` in DELAY_WIDTH: delay for this run.
- `cmd_count` in AW+1: number of entries to issue.
- `cmd_err` out 1: one-cycle pulse when a start is rejected.
- `abort` in 1: terminate the current run.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse on normal completion.
- `aborted` out 1: one-cycle pulse on abort.
- `reset` out 1: shifter reset, one-cycle pulse.
- `delay_value` out DELAY_WIDTH: delay presented to the shifter.
- `delay_set` out 1: delay load strobe.
- `event_value` out EVENT_WIDTH: event presented to the shifter.
- `event_set` out 1: event load strobe.
- `event_polarity_set` out 1: polarity strobe.

## Operation
- **Reset values.** All outputs are 0 during and after reset, except `cmd_ready`, which is 1. The FSM resets to IDLE. Table contents are undefined until written.
- **FSM states:** IDLE, RST, DLY, EVT, GAPW, DONE, ABRT.
- **Start accepted.** When `cmd_start` is high in IDLE and `cmd_count` ≤ DEPTH:
  - latch `cmd_delay` and `cmd_count`;
  - clear the entry index;
  - go to RST.
- **Start rejected.** When `cmd_start` is high in IDLE and `cmd_count` > DEPTH: pulse `cmd_err` and stay in IDLE.
- **Start outside IDLE.** `cmd_start` is ignored.
- **RST.** Assert `reset` for 1 cycle, then go to GAPW.
- **DLY.** Assert `delay_set` for 1 cycle with the latched delay on `delay_value`, then go to GAPW.
- **EVT.** Assert `event_set` for 1 cycle with `event_value` = entry[index].event, and `event_polarity_set` = entry[index].polarity in the same cycle. Increment the index, then go to GAPW.
- **GAPW.** Wait exactly GAP cycles. Next state:
  - DLY after RST;
  - EVT while index < count;
  - DONE otherwise.
- **DONE.** Pulse `done` for 1 cycle, then go to IDLE.
- **Zero count.** `cmd_count` = 0 is legal: the run performs RST and DLY only, then DONE.
- **Abort.** `abort` sampled high in any non-IDLE state goes to ABRT the next cycle. ABRT asserts `reset` and `aborted` together for 1 cycle, then goes to IDLE; `done` is not pulsed. A strobe already asserted in the sampling cycle completes. `abort` in IDLE has no effect.
- **Table writes.** A write is accepted in IDLE only. A write while `busy` is dropped and `cfg_wr_err` pulses.
- **Table read.** Synchronous; the read for entry *i* is issued during the preceding GAPW, so `event_value` is registered in EVT.
- **Data buses.** `delay_value` and `event_value` hold their last value between strobes.
- **Entry order.** Entries are issued in index order 0 … count−1; there is no wrap-around.

## Timing
- Start accepted at edge 0. Strobes then fall on these cycles:
  - `reset` at cycle 1;
  - `delay_set` at cycle 2+GAP;
  - event k at cycle 3+2·GAP+k·(1+GAP);
  - `done` at cycle 3+2·GAP+count·(1+GAP).
- `cmd_ready` returns high on the cycle after `done` or `aborted`. Back-to-back starts are therefore separated by at least 1 IDLE cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- **`SHIFTER_SEQ_READBACK_EN` defined:** adds ports `rd_addr` (in, AW) and `rd_data` (out, EVENT_WIDTH+1). A read has 1-cycle latency and is valid in any state. `rd_data` resets to 0.
- **`SHIFTER_SEQ_READBACK_EN` undefined:** these ports are absent and the table is write-only.

## Test plan
- **Normal run:** write entries 0–2 = `{0,5}`, `{1,7}`, `{0,9}`; GAP=2; start with delay=100, count=3.
  - `reset` pulses at cycle 1;
  - `delay_set` pulses at cycle 4 with value 100;
  - `event_set` pulses at cycles 7, 10, 13 with values 5, 7, 9;
  - `event_polarity_set` pulses only at cycle 10;
  - `done` pulses at cycle 16.
- **Zero count:** start with count=0 → `reset` at cycle 1, `delay_set` at cycle 4, `done` at cycle 7, no `event_set`.
- **Over-range count:** start with count=DEPTH+1 → `cmd_err` pulses for 1 cycle, `busy` stays 0, and no shifter strobes occur.
- **Abort mid-run:** assert `abort` at cycle 8 of the normal run → `reset` and `aborted` pulse at cycle 9, there is no further `event_set`, no `done`, and `cmd_ready` is 1 at cycle 10.
- **Write while busy:** write during a run → `cfg_wr_err` pulses and the table is unchanged. A later run re-emits the original values.
- **Async reset mid-run:** pull `s_axi_aresetn` low mid-run → all strobes drop to 0 immediately and `cmd_ready` is 1 after release. With `SHIFTER_SEQ_READBACK_EN` defined, `rd_data` at address 1 reads `{1,7}`.
